alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 41 ++++
 rtl/alu_issue_dec.sv | 68 ++++++
 rtl/alu_issue.sv | 115 +++++++++++
 tb/tb_alu_issue.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
// Shared constants for the alu_issue slice: MIPS opcode and funct encodings,
// the ALU operation codes driven to the external ALU, and the issue FSM state
// encoding. Imported by alu_issue_dec and alu_issue.
package alu_issue_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LUI   = 6'b001111;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;

  // Operation codes understood by the external ALU
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SRL = 3'd4,
    ALU_SRA = 3'd5
  } alu_op_e;

  // Issue FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_dec.sv
// alu_issue_dec
// Purely combinational MIPS decoder. Maps an instruction word and its two
// register operands onto an ALU operation and the two ALU operands.
// Ports:
//   instr       - instruction word
//   rs_val      - rs register operand
//   rt_val      - rt register operand
//   op          - ALU operation code
//   a, b        - ALU operands
//   unsupported - high when the encoding is not one this block executes
//                 (op/a/b are then ADD/0/0 so the ALU produces 0)
module alu_issue_dec
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output alu_op_e         op,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic            unsupported
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        unused_reg_fields;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign shamt  = instr[10:6];
  assign imm    = instr[15:0];
  // Register numbers are resolved upstream; only their values arrive here.
  assign unused_reg_fields = ^instr[25:16];

  // Every path starts from the unsupported no-op and overrides it on a match.
  // Shifts put the shifted value on A and the 5-bit amount on B.
  always_comb begin
    op          = ALU_ADD;
    a           = '0;
    b           = '0;
    unsupported = 1'b1;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADDU: begin op = ALU_ADD; a = rs_val; b = rt_val; unsupported = 1'b0; end
          FN_SUBU: begin op = ALU_SUB; a = rs_val; b = rt_val; unsupported = 1'b0; end
          FN_AND:  begin op = ALU_AND; a = rs_val; b = rt_val; unsupported = 1'b0; end
          FN_OR:   begin op = ALU_OR;  a = rs_val; b = rt_val; unsupported = 1'b0; end
          FN_SRLV: begin op = ALU_SRL; a = rt_val; b = {{(XLEN-5){1'b0}}, rs_val[4:0]}; unsupported = 1'b0; end
          FN_SRAV: begin op = ALU_SRA; a = rt_val; b = {{(XLEN-5){1'b0}}, rs_val[4:0]}; unsupported = 1'b0; end
          FN_SRL:  begin op = ALU_SRL; a = rt_val; b = {{(XLEN-5){1'b0}}, shamt}; unsupported = 1'b0; end
          FN_SRA:  begin op = ALU_SRA; a = rt_val; b = {{(XLEN-5){1'b0}}, shamt}; unsupported = 1'b0; end
          default: ;
        endcase
      end
      OPC_ADDIU: begin op = ALU_ADD; a = rs_val; b = {{(XLEN-16){imm[15]}}, imm}; unsupported = 1'b0; end
      OPC_ANDI:  begin op = ALU_AND; a = rs_val; b = {{(XLEN-16){1'b0}}, imm};    unsupported = 1'b0; end
      OPC_ORI:   begin op = ALU_OR;  a = rs_val; b = {{(XLEN-16){1'b0}}, imm};    unsupported = 1'b0; end
      OPC_LUI:   begin op = ALU_ADD; a = '0;     b = {imm, {(XLEN-16){1'b0}}};    unsupported = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue
// Issues one MIPS ALU instruction at a time to an external combinational ALU
// and returns the result over a valid/ready handshake. Each command walks
// IDLE -> EXEC -> DONE, so at most one command is in flight.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   in_valid, in_ready    - command handshake
//   instr, rs_val, rt_val - instruction word and register operands
//   alu_a, alu_b, alu_op  - registered drive to the external ALU
//   alu_c                 - external ALU result
//   out_valid, out_ready  - result handshake
//   out_result, out_err   - result and unsupported-instruction flag
// Configuration:
//   ALU_ISSUE_ERR_EN - when defined, out_err flags unsupported encodings;
//                      otherwise out_err is tied low.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  input  logic [XLEN-1:0] alu_c,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_err
);

  state_e          state;
  alu_op_e         dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic            dec_unsupported;
  logic            unsupported_q;

  alu_issue_dec #(.XLEN(XLEN)) u_dec (
    .instr       (instr),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .op          (dec_op),
    .a           (dec_a),
    .b           (dec_b),
    .unsupported (dec_unsupported)
  );

  // Single FSM with registered handshake outputs. The ALU drive is captured
  // on accept and left untouched until the next accept, which keeps it
  // stable through EXEC and DONE. Unsupported commands are forced to a zero
  // result instead of trusting the external ALU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_result    <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= 3'd0;
      unsupported_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            alu_op        <= dec_op;
            alu_a         <= dec_a;
            alu_b         <= dec_b;
            unsupported_q <= dec_unsupported;
            in_ready      <= 1'b0;
            state         <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_result <= unsupported_q ? '0 : alu_c;
          out_valid  <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_ERR_EN
  // Error flag is captured alongside the result so it holds with it in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_err <= 1'b0;
    end else if (state == ST_EXEC) begin
      out_err <= unsupported_q;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue
// Self-checking bench for alu_issue. Provides a behavioural external ALU,
// a mnemonic-level reference model of each command and its handshake
// timing, a per-cycle compare process, and directed commands with
// hand-computed expected values.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_c;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;

  int errors = 0;
  int checks = 0;

  // Values seen at the moment out_valid rose for the last command
  logic [31:0] got_result, got_a, got_b;
  logic [2:0]  got_op;
  logic        got_err;
  logic        exp_unsup_err;

  alu_issue #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_c      (alu_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  // External ALU
  always_comb begin
    alu_c = 32'h0;
    case (alu_op)
      3'd0: alu_c = alu_a + alu_b;
      3'd1: alu_c = alu_a - alu_b;
      3'd2: alu_c = alu_a & alu_b;
      3'd3: alu_c = alu_a | alu_b;
      3'd4: alu_c = alu_a >> alu_b[4:0];
      3'd5: alu_c = $signed(alu_a) >>> alu_b[4:0];
      default: alu_c = 32'h0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference meaning of each instruction, written per mnemonic.
  function automatic void modelCmd(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                                   output logic [2:0] op, output logic [31:0] a, output logic [31:0] b,
                                   output logic [31:0] res, output logic err);
    logic [15:0] imm;
    logic [4:0]  sh;
    logic        bad;
    imm = i[15:0];
    sh  = i[10:6];
    op = 3'd0; a = 32'h0; b = 32'h0; res = 32'h0; bad = 1'b0;
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h21: begin op = 3'd0; a = rs; b = rt; res = rs + rt; end
        6'h23: begin op = 3'd1; a = rs; b = rt; res = rs - rt; end
        6'h24: begin op = 3'd2; a = rs; b = rt; res = rs & rt; end
        6'h25: begin op = 3'd3; a = rs; b = rt; res = rs | rt; end
        6'h06: begin op = 3'd4; a = rt; b = {27'h0, rs[4:0]}; res = rt >> rs[4:0]; end
        6'h07: begin op = 3'd5; a = rt; b = {27'h0, rs[4:0]}; res = $signed(rt) >>> rs[4:0]; end
        6'h02: begin op = 3'd4; a = rt; b = {27'h0, sh}; res = rt >> sh; end
        6'h03: begin op = 3'd5; a = rt; b = {27'h0, sh}; res = $signed(rt) >>> sh; end
        default: bad = 1'b1;
      endcase
    end else begin
      case (i[31:26])
        6'h09: begin op = 3'd0; a = rs; b = {{16{imm[15]}}, imm}; res = rs + {{16{imm[15]}}, imm}; end
        6'h0C: begin op = 3'd2; a = rs; b = {16'h0, imm}; res = rs & {16'h0, imm}; end
        6'h0D: begin op = 3'd3; a = rs; b = {16'h0, imm}; res = rs | {16'h0, imm}; end
        6'h0F: begin op = 3'd0; a = 32'h0; b = {imm, 16'h0}; res = {imm, 16'h0}; end
        default: bad = 1'b1;
      endcase
    end
`ifdef ALU_ISSUE_ERR_EN
    err = bad;
`else
    err = 1'b0;
`endif
  endfunction

  // Model of the command lifecycle: 0 = idle, 1 = executing, 2 = result shown
  int          m_phase;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_res;
  logic        m_err;

  always @(posedge clk or negedge reset) begin : model_proc
    logic [2:0]  t_op;
    logic [31:0] t_a, t_b, t_res;
    logic        t_err;
    if (!reset) begin
      m_phase <= 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          modelCmd(instr, rs_val, rt_val, t_op, t_a, t_b, t_res, t_err);
          m_op <= t_op; m_a <= t_a; m_b <= t_b; m_res <= t_res; m_err <= t_err;
          m_phase <= 1;
        end
        1: m_phase <= 2;
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  // Compare process: every falling edge, DUT outputs against the model
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("rst in_ready", 32'(in_ready), 32'h1);
      checkOutput("rst out_valid", 32'(out_valid), 32'h0);
      checkOutput("rst out_err", 32'(out_err), 32'h0);
      checkOutput("rst out_result", out_result, 32'h0);
      checkOutput("rst alu_a", alu_a, 32'h0);
      checkOutput("rst alu_b", alu_b, 32'h0);
      checkOutput("rst alu_op", 32'(alu_op), 32'h0);
    end else begin
      checkOutput("in_ready", 32'(in_ready), 32'(m_phase == 0));
      checkOutput("out_valid", 32'(out_valid), 32'(m_phase == 2));
      if (m_phase != 0) begin
        checkOutput("alu_op", 32'(alu_op), 32'(m_op));
        checkOutput("alu_a", alu_a, m_a);
        checkOutput("alu_b", alu_b, m_b);
      end
      if (m_phase == 2) begin
        checkOutput("out_result", out_result, m_res);
        checkOutput("out_err", 32'(out_err), 32'(m_err));
      end
    end
  end

  // Issues one command (caller sits at a falling edge), measures the cycle
  // at which out_valid appears counting the accept cycle as 0, holds
  // out_ready low for 'hold' cycles, then completes the handshake. Returns
  // at the falling edge after the handshake edge.
  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt, input int hold);
    int cyc;
    instr = i; rs_val = rs; rt_val = rt; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("valid cycle after accept", 32'(cyc), 32'd2);
    got_result = out_result; got_err = out_err;
    got_a = alu_a; got_b = alu_b; got_op = alu_op;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
`ifdef ALU_ISSUE_ERR_EN
    exp_unsup_err = 1'b1;
`else
    exp_unsup_err = 1'b0;
`endif
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'h0; rs_val = 32'h0; rt_val = 32'h0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    // addu wraps into the sign bit; issued right after reset release
    applyStimulus(32'h0000_0021, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    checkOutput("addu op", 32'(got_op), 32'd0);
    checkOutput("addu result", got_result, 32'h8000_0000);

    // sra by shamt 4
    applyStimulus(32'h0000_0103, 32'h0, 32'hF000_0000, 0);
    checkOutput("sra op", 32'(got_op), 32'd5);
    checkOutput("sra b", got_b, 32'h4);
    checkOutput("sra result", got_result, 32'hFF00_0000);

    // srlv uses rs[4:0] only
    applyStimulus(32'h0000_0006, 32'h0000_0024, 32'hF000_0000, 0);
    checkOutput("srlv b", got_b, 32'h4);
    checkOutput("srlv result", got_result, 32'h0F00_0000);

    // lui and addiu with negative immediate
    applyStimulus(32'h3C00_1234, 32'hDEAD_BEEF, 32'h0, 0);
    checkOutput("lui a", got_a, 32'h0);
    checkOutput("lui b", got_b, 32'h1234_0000);
    checkOutput("lui result", got_result, 32'h1234_0000);
    applyStimulus(32'h2400_FFFF, 32'h0000_0005, 32'h0, 0);
    checkOutput("addiu result", got_result, 32'h0000_0004);

    // subu with a 5-cycle back-pressure, then back-to-back commands
    applyStimulus(32'h0000_0023, 32'h0000_0003, 32'h0000_0005, 5);
    checkOutput("subu result", got_result, 32'hFFFF_FFFE);
    applyStimulus(32'h0000_0024, 32'hFF00_FF00, 32'h0F0F_0F0F, 1);
    checkOutput("and result", got_result, 32'h0F00_0F00);
    applyStimulus(32'h0000_0025, 32'hFF00_0000, 32'h0000_00FF, 0);
    checkOutput("or result", got_result, 32'hFF00_00FF);
    applyStimulus(32'h0000_0007, 32'h0000_003F, 32'h8000_0000, 2);
    checkOutput("srav result", got_result, 32'hFFFF_FFFF);
    applyStimulus(32'h0000_07C2, 32'h0, 32'h8000_0000, 0);
    checkOutput("srl result", got_result, 32'h0000_0001);
    applyStimulus(32'h3000_8001, 32'hFFFF_FFFF, 32'h0, 0);
    checkOutput("andi result", got_result, 32'h0000_8001);
    applyStimulus(32'h3400_8000, 32'h0000_0001, 32'h0, 0);
    checkOutput("ori result", got_result, 32'h0000_8001);

    // Unsupported encodings, including ones whose operands look live
    applyStimulus(32'hFC00_0000, 32'h1234_5678, 32'h1111_1111, 3);
    checkOutput("unsup result", got_result, 32'h0);
    checkOutput("unsup err", 32'(got_err), 32'(exp_unsup_err));
    applyStimulus(32'h0000_003F, 32'h1234_5678, 32'h1111_1111, 0);
    checkOutput("bad funct result", got_result, 32'h0);
    checkOutput("bad funct err", 32'(got_err), 32'(exp_unsup_err));

    // Reset pulsed while the command is in EXEC
    instr = 32'h0000_0021; rs_val = 32'h1; rt_val = 32'h2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("exec rst in_ready", 32'(in_ready), 32'h1);
    checkOutput("exec rst out_valid", 32'(out_valid), 32'h0);
    checkOutput("exec rst alu_a", alu_a, 32'h0);
    checkOutput("exec rst alu_b", alu_b, 32'h0);
    checkOutput("exec rst alu_op", 32'(alu_op), 32'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("abandoned out_valid", 32'(out_valid), 32'h0);

    // Normal operation after the abandoned command
    applyStimulus(32'h0000_0021, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    checkOutput("post-reset addu", got_result, 32'h0000_0001);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
